// File: rtl/dbus_responder.sv
// Single-port data-bus responder: on-chip 64-bit word RAM with a programmable
// response latency, one request in flight at a time.
module dbus_responder #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [64:0] LIMIT    = {1'b0, BASE} + (65'(DEPTH) << 3);
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          data_ok_q;
  logic          resp_err_q;
  logic [63:0]   resp_data_q;
  logic [63:0]   mem [DEPTH];

  logic          accept;
  logic          range_err;
  logic          align_err;
  logic          acc_err;
  logic [AW-1:0] idx;
  logic [63:0]   rd_word;

  assign accept    = (state_q == S_IDLE) && req_valid && reset;
  assign range_err = (req_addr < BASE) || ({1'b0, req_addr} >= LIMIT);
  assign acc_err   = range_err || align_err;
  assign idx       = AW'((req_addr - BASE) >> 3);
  assign rd_word   = mem[idx];

  always_comb begin
    align_err = 1'b0;
    case (req_size)
      3'd0:    align_err = 1'b0;
      3'd1:    align_err = req_addr[0];
      3'd2:    align_err = |req_addr[1:0];
      3'd3:    align_err = |req_addr[2:0];
      default: align_err = 1'b1;
    endcase
  end

  // Response word is captured before the store lands (read-before-write).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      data_ok_q   <= 1'b0;
      resp_data_q <= 64'd0;
      resp_err_q  <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            resp_err_q  <= acc_err;
            resp_data_q <= acc_err ? 64'd0 : rd_word;
            cnt_q       <= CNT_INIT;
            if (LATENCY == 0) begin
              state_q   <= S_RESP;
              data_ok_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q   <= S_RESP;
            data_ok_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Array is deliberately not reset; contents survive a mid-flight abort.
  always_ff @(posedge clk) begin
    if (accept && !acc_err) begin
      for (int i = 0; i < 8; i++) begin
        if (req_strobe[i]) mem[idx][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

  assign addr_ok   = accept;
  assign data_ok   = data_ok_q;
  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized bench for dbus_responder: a cycle-level reference model checks
// handshake timing and response contents every cycle.
module tb_dbus_responder;

  localparam int          DEPTH = 512;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [2:0]  req_size = 3'd0;
  logic [7:0]  req_strobe = 8'd0;
  logic [63:0] req_data = 64'd0;
  logic        addr_ok, data_ok, resp_err, busy;
  logic [63:0] resp_data;

  dbus_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_strobe(req_strobe),
    .req_data  (req_data),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory with per-byte "written" flags
  logic [63:0] mdata [DEPTH];
  logic [7:0]  mvalid [DEPTH];
  bit          started = 0;
  bit          prev_rst_low = 0;
  int          acc_c = -100;
  int          dok_c = -100;
  int          free_c = 0;
  logic [63:0] e_rd, e_mask;
  logic        e_err;

  function automatic bit model_err(input logic [63:0] a, input logic [2:0] s);
    logic [64:0] lim;
    bit          r;
    lim = {1'b0, BASE} + 65'(DEPTH) * 65'd8;
    r = (a < BASE) || ({1'b0, a} >= lim);
    if (s > 3'd3) return 1'b1;
    return r || ((a % (64'd1 << s)) != 64'd0);
  endfunction

  always @(negedge clk) begin
    bit exp_aok;
    int w;
    exp_aok = reset && req_valid && (cyc >= free_c);
    if (started) begin
      check("addr_ok", 64'(addr_ok), 64'(exp_aok));
      check("data_ok", 64'(data_ok), 64'(cyc == dok_c));
      check("busy", 64'(busy), 64'(cyc > acc_c && cyc <= dok_c));
      if (prev_rst_low) begin
        check("reset resp_data", resp_data, 64'd0);
        check("reset resp_err", 64'(resp_err), 64'd0);
      end
      if (cyc == dok_c) begin
        check("resp_err", 64'(resp_err), 64'(e_err));
        check("resp_data", resp_data & e_mask, e_rd & e_mask);
      end
    end
    if (!reset) begin
      started = 1;
      acc_c   = -100;
      dok_c   = -100;
      free_c  = cyc + 1;
    end else if (started && exp_aok) begin
      e_err = model_err(req_addr, req_size);
      w = int'(((req_addr - BASE) >> 3) % DEPTH);
      if (e_err) begin
        e_rd   = 64'd0;
        e_mask = '1;
      end else begin
        e_rd   = mdata[w];
        e_mask = 64'd0;
        for (int i = 0; i < 8; i++) begin
          if (mvalid[w][i]) e_mask = e_mask | (64'hFF << (8 * i));
          if (req_strobe[i]) begin
            mdata[w] = (mdata[w] & ~(64'hFF << (8 * i))) | (req_data & (64'hFF << (8 * i)));
            mvalid[w][i] = 1'b1;
          end
        end
      end
      acc_c  = cyc;
      dok_c  = cyc + LAT + 1;
      free_c = cyc + LAT + 2;
    end
    prev_rst_low = !reset;
  end

  task automatic txn(input logic [63:0] a, input logic [2:0] s, input logic [7:0] st,
                     input logic [63:0] d, input bit drop,
                     output int t_acc, output int lat, output logic [63:0] rd, output logic re);
    @(posedge clk); #1;
    req_addr = a; req_size = s; req_strobe = st; req_data = d; req_valid = 1'b1;
    t_acc = -1; lat = -1; rd = 64'd0; re = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (addr_ok) begin t_acc = cyc; break; end
    end
    if (t_acc < 0) begin
      check("accept timeout", 64'd0, 64'd1);
      return;
    end
    if (drop) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr = {$urandom, $urandom}; req_size = 3'($urandom);
      req_strobe = 8'($urandom); req_data = {$urandom, $urandom};
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (data_ok) begin lat = cyc - t_acc; rd = resp_data; re = resp_err; break; end
    end
    if (lat < 0) check("data_ok timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int          ta, tb, lt;
    logic [63:0] rd;
    logic        re;
    logic [63:0] a;
    logic [2:0]  s;
    int          w, r, off;

    for (int i = 0; i < DEPTH; i++) begin
      mdata[i] = 64'd0;
      mvalid[i] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    txn(BASE, 3'd3, 8'hFF, 64'h1122334455667788, 1'b0, ta, lt, rd, re);
    check("wr latency", 64'(lt), 64'd3);
    check("wr err", 64'(re), 64'd0);
    txn(BASE, 3'd3, 8'h00, 64'd0, 1'b0, ta, lt, rd, re);
    check("rd full word", rd, 64'h1122334455667788);

    txn(BASE, 3'd3, 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b0, ta, lt, rd, re);
    txn(BASE, 3'd3, 8'h00, 64'd0, 1'b0, ta, lt, rd, re);
    check("rd partial strobe", rd, 64'h11223344BBBBBBBB);

    txn(BASE + 64'd2, 3'd2, 8'h0F, 64'hDEADBEEFDEADBEEF, 1'b0, ta, lt, rd, re);
    check("misalign latency", 64'(lt), 64'd3);
    check("misalign err", 64'(re), 64'd1);
    check("misalign data", rd, 64'd0);
    txn(BASE, 3'd3, 8'h00, 64'd0, 1'b0, ta, lt, rd, re);
    check("rd after misalign", rd, 64'h11223344BBBBBBBB);

    txn(64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, 1'b0, ta, lt, rd, re);
    check("below base err", 64'(re), 64'd1);
    txn(BASE + 64'(8 * DEPTH), 3'd3, 8'h00, 64'd0, 1'b0, ta, lt, rd, re);
    check("past end err", 64'(re), 64'd1);
    txn(64'h8000_0FF8, 3'd3, 8'h00, 64'd0, 1'b0, ta, lt, rd, re);
    check("last word err", 64'(re), 64'd0);

    idle(2);
    txn(BASE + 64'd16, 3'd3, 8'hFF, 64'h0102030405060708, 1'b0, ta, lt, rd, re);
    txn(BASE + 64'd16, 3'd3, 8'h00, 64'd0, 1'b0, tb, lt, rd, re);
    check("b2b second accept", 64'(tb - ta), 64'd4);
    check("b2b second latency", 64'(lt), 64'd3);
    check("b2b read", rd, 64'h0102030405060708);

    // Abort a store mid-flight; the store itself must still land.
    idle(2);
    @(posedge clk); #1;
    req_addr = BASE + 64'd8; req_size = 3'd0; req_strobe = 8'h01;
    req_data = 64'h0000_0000_0000_0055; req_valid = 1'b1;
    ta = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (addr_ok) begin ta = cyc; break; end
    end
    check("reset-seq accept seen", 64'(ta >= 0), 64'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("addr_ok in reset", 64'(addr_ok), 64'd0);
    @(negedge clk);
    check("busy after reset", 64'(busy), 64'd0);
    check("data_ok after reset", 64'(data_ok), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("no late data_ok", 64'(data_ok), 64'd0);
    end
    txn(BASE + 64'd8, 3'd3, 8'h00, 64'd0, 1'b0, ta, lt, rd, re);
    check("byte after abort", 64'(rd[7:0]), 64'h55);

    for (int i = 0; i < 16; i++)
      txn(BASE + 64'(8 * i), 3'd3, 8'hFF, {$urandom, $urandom}, 1'b0, ta, lt, rd, re);
    for (int i = DEPTH - 2; i < DEPTH; i++)
      txn(BASE + 64'(8 * i), 3'd3, 8'hFF, {$urandom, $urandom}, 1'b0, ta, lt, rd, re);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) w = $urandom_range(0, 15);
      else w = DEPTH - 1 - $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      s = (r < 8) ? 3'(r % 4) : 3'($urandom_range(4, 7));
      if ($urandom_range(0, 3) == 0 || s > 3'd3) off = $urandom_range(0, 7);
      else off = ($urandom_range(0, 7) >> s) << s;
      a = BASE + 64'(8 * w + off);
      r = $urandom_range(0, 9);
      if (r == 8) a = (($urandom_range(0, 1) == 0) ? BASE - 64'd8 : BASE + 64'(8 * DEPTH));
      if (r == 9) a = {$urandom, $urandom};
      txn(a, s, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom},
          ($urandom_range(0, 3) == 0), ta, lt, rd, re);
      check("rand latency", 64'(lt), 64'(LAT + 1));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
